// File: rtl/aes_mix_columns_seq_if.sv
// Valid/ready bus between the shift-rows stage, the MixColumns engine and AddRoundKey.
interface aes_mix_columns_seq_if #(
    parameter int unsigned DATA_W = 128
);
    logic              valid_in;
    logic              ready_in;
    logic              inv_in;
    logic [DATA_W-1:0] data_in;
    logic              valid_out;
    logic              ready_out;
    logic [DATA_W-1:0] data_out;

    modport master (
        output valid_in, inv_in, data_in, ready_out,
        input  ready_in, valid_out, data_out
    );

    modport slave (
        input  valid_in, inv_in, data_in, ready_out,
        output ready_in, valid_out, data_out
    );
endinterface

// File: rtl/aes_mix_columns_seq.sv
// Column-serial forward/inverse AES MixColumns with valid/ready on both sides.
// COLS_PER_CYCLE columns (1, 2 or 4) are transformed per BUSY cycle.
module aes_mix_columns_seq #(
    parameter int unsigned COLS_PER_CYCLE = 1,
    parameter int unsigned DATA_W         = 128
) (
    input logic                  clk,
    input logic                  reset,
    aes_mix_columns_seq_if.slave bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int unsigned NCOL     = 4;
    localparam logic [1:0]  COL_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0]  LAST_COL = 2'(NCOL - COLS_PER_CYCLE);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
        $error("aes_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end
    if (DATA_W != 128) begin : g_bad_width
        $error("aes_mix_columns_seq: DATA_W must be 128");
    end

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One column; packed index 3 holds row 0 so the column word reads MSB-first.
    function automatic logic [31:0] mix_col(input logic [3:0][7:0] col, input logic inv);
        logic [3:0][7:0] b, x2, x4, x8, res;
        logic [1:0]      j0, j1, j2, j3;
        for (int i = 0; i < 4; i++) begin
            b[2'(i)]  = col[2'(3 - i)];
            x2[2'(i)] = xtime(b[2'(i)]);
            x4[2'(i)] = xtime(x2[2'(i)]);
            x8[2'(i)] = xtime(x4[2'(i)]);
        end
        for (int r = 0; r < 4; r++) begin
            j0 = 2'(r);
            j1 = j0 + 2'd1;
            j2 = j0 + 2'd2;
            j3 = j0 + 2'd3;
            if (inv) begin
                res[2'(3 - r)] = (x8[j0] ^ x4[j0] ^ x2[j0])
                               ^ (x8[j1] ^ x2[j1] ^ b[j1])
                               ^ (x8[j2] ^ x4[j2] ^ b[j2])
                               ^ (x8[j3] ^ b[j3]);
            end else begin
                res[2'(3 - r)] = x2[j0] ^ (x2[j1] ^ b[j1]) ^ b[j2] ^ b[j3];
            end
        end
        return res;
    endfunction

    logic [1:0]        state_q, state_d;
    logic [1:0]        col_idx_q, col_idx_d;
    logic [3:0][31:0]  in_q, in_d;
    logic              inv_q, inv_d;
    logic [3:0][31:0]  res_q, res_d;
    logic              valid_q, valid_d;
    logic [1:0]        slot;
    logic              ready;
    logic              accept;

    // ready_in never looks at valid_in, so upstream can wait on it safely.
    assign ready  = reset && ((state_q == IDLE) || ((state_q == DONE) && bus.ready_out));
    assign accept = bus.valid_in && ready;

    assign bus.ready_in  = ready;
    assign bus.valid_out = valid_q;
    assign bus.data_out  = res_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            col_idx_q <= 2'd0;
            in_q      <= '0;
            inv_q     <= 1'b0;
            res_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_idx_q <= col_idx_d;
            in_q      <= in_d;
            inv_q     <= inv_d;
            res_q     <= res_d;
            valid_q   <= valid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        col_idx_d = col_idx_q;
        in_d      = in_q;
        inv_d     = inv_q;
        res_d     = res_q;
        valid_d   = valid_q;
        slot      = 2'd0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    in_d      = bus.data_in;
                    inv_d     = bus.inv_in;
                    col_idx_d = 2'd0;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                for (int unsigned k = 0; k < COLS_PER_CYCLE; k++) begin
                    slot        = 2'(NCOL - 1) - col_idx_q - 2'(k);
                    res_d[slot] = mix_col(in_q[slot], inv_q);
                end
                col_idx_d = col_idx_q + COL_STEP;
                if (col_idx_q == LAST_COL) begin
                    state_d = DONE;
                    valid_d = 1'b1;
                end
            end
            DONE: begin
                if (bus.ready_out) begin
                    valid_d = 1'b0;
                    if (bus.valid_in) begin
                        in_d      = bus.data_in;
                        inv_d     = bus.inv_in;
                        col_idx_d = 2'd0;
                        state_d   = BUSY;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

endmodule
